bam_product_accumulator: RTL and testbench
==========================================

BAM_PRODUCT_ACCUMULATOR -- requirements
Module: bam_product_accumulator

Interface
REQ-001 SHALL provide parameter ACC_W, default 24, giving the accumulator and result width in bits (legal range 17..32).
REQ-002 SHALL provide parameter CNT_W, default 8, giving the product-count width in bits (legal range 2..16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  in_prod/in_last are valid this cycle.
REQ-006 in_ready  output  1  block accepts a product this cycle.
REQ-007 in_prod  input  16  unsigned product from the 8x8 approximate multiplier.
REQ-008 in_last  input  1  marks the final product of the current group.
REQ-009 out_valid  output  1  result registers hold a completed group.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 out_sum  output  ACC_W  saturated unsigned sum of the group.
REQ-012 out_count  output  CNT_W  number of products in the group, saturating.
REQ-013 out_sat  output  1  sticky flag: the sum saturated at least once in the group.

Function
REQ-014 SHALL implement a two-state FSM, ACCUM and HOLD; the reset state SHALL be ACCUM.
REQ-015 In ACCUM, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0. in_ready SHALL come from registered state only, with no combinational path from in_valid or out_ready.
REQ-016 An input handshake SHALL be in_valid && in_ready; in_valid, in_prod and in_last SHALL be ignored in every other cycle.
REQ-017 On each input handshake, acc SHALL become min(acc + zero-extended in_prod, 2^ACC_W-1).
REQ-018 The addition in REQ-017 SHALL be evaluated at ACC_W+1 bits so that overflow is detected, never wrapped.
REQ-019 On each input handshake, cnt SHALL become min(cnt+1, 2^CNT_W-1).
REQ-020 sat SHALL be set when an addition clamps, and SHALL stay set until the group is cleared.
REQ-021 On a handshake with in_last=1, out_sum, out_count and out_sat SHALL load the post-update acc, cnt and sat values (the last product is included).
REQ-022 In the same case, the FSM SHALL enter HOLD, and out_valid SHALL be 1 in the next cycle (latency 1 clock from the last accepted product).
REQ-023 In HOLD, out_valid SHALL be 1. out_sum, out_count and out_sat SHALL stay stable until an output handshake (out_valid && out_ready).
REQ-024 On the output handshake, the FSM SHALL return to ACCUM, clear acc, cnt and sat to 0, and drive out_valid to 0 in the next cycle.
REQ-025 A new group SHALL be accepted from the cycle after the output handshake, giving at most one product per cycle and one idle input cycle per group.
REQ-026 A group of one product (in_valid && in_last on the first accepted beat) SHALL give out_sum=in_prod and out_count=1.
REQ-027 out_sum, out_count and out_sat SHALL stay driven with the last result while out_valid=0; downstream SHALL qualify them only with out_valid.
REQ-028 in_prod=0 SHALL still count as a product: cnt increments and acc is unchanged.
REQ-029 The block SHALL be purely unsigned, with no rounding and no truncation other than the saturation in REQ-017 and REQ-019.

Reset
REQ-030 While rst=1 at a rising edge, the block SHALL set state=ACCUM and acc=0, cnt=0, sat=0.
REQ-031 The same reset SHALL set out_valid=0, out_sum=0, out_count=0 and out_sat=0.
REQ-032 in_ready SHALL read 1 in the first cycle after rst deasserts.
REQ-033 Reset SHALL take priority over any simultaneous input or output handshake.
REQ-034 Reset asserted mid-group or in HOLD SHALL discard the partial or pending result, with no output handshake occurring.

Verification
REQ-035 Products 100, 200, 300 (last on 300), out_ready=1 -> one cycle after the 300 beat: out_valid=1, out_sum=600, out_count=3, out_sat=0.
REQ-036 With ACC_W=18, five products of 65535 (last on the fifth) -> out_sum=262143, out_count=5, out_sat=1.
REQ-037 Group 7, 8 (last), then out_ready=0 for 5 cycles, in_valid=1 throughout -> out_sum=15 stable and in_ready=0 for all 5 cycles.
REQ-038 Continuing REQ-037: out_ready=1 -> out_valid=0 next cycle; next group 5 (last) -> out_sum=5, out_count=1, so no carry-over from the prior group.
REQ-039 With CNT_W=4, twenty products of 1 (last on the twentieth) -> out_count=15, out_sum=20, out_sat=0.
REQ-040 rst=1 for one cycle while in HOLD with out_sum=600 -> out_valid=0, out_sum=0, in_ready=1 the cycle after release; next group 9 (last) -> out_sum=9.

Source files
------------

// File: rtl/bam_product_accumulator.sv
// bam_product_accumulator: saturating accumulator of 16-bit products into per-group sum/count results with a ready/valid handshake on each side.
module bam_product_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sat, sat_n;
  logic [ACC_W:0]   sum_w;
  logic             in_hs, out_hs;
  assign in_ready  = state == ACCUM;
  assign out_valid = state == HOLD;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  // one extra bit so a carry out marks a clamp instead of wrapping
  assign sum_w     = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, in_prod};
  always_comb begin
    acc_n   = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
    cnt_n   = &cnt ? cnt : cnt + 1'b1;
    sat_n   = sat | sum_w[ACC_W];
    state_n = state == ACCUM ? (in_hs && in_last ? HOLD : ACCUM)
                             : (out_ready ? ACCUM : HOLD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      state <= state_n;
      if (out_hs) begin
        acc <= '0;
        cnt <= '0;
        sat <= 1'b0;
      end else if (in_hs) begin
        acc <= acc_n;
        cnt <= cnt_n;
        sat <= sat_n;
      end
      if (in_hs && in_last) begin
        out_sum   <= acc_n;
        out_count <= cnt_n;
        out_sat   <= sat_n;
      end
    end
  end
endmodule

// File: tb/tb_bam_product_accumulator.sv
// tb_bam_product_accumulator: scoreboard bench driving three parameterisations of the accumulator in lockstep.
module tb_bam_product_accumulator;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] in_prod = 0;
  logic [2:0] in_ready, out_valid, out_sat;
  logic [23:0] sum0, sum2;
  logic [17:0] sum1;
  logic [7:0] cnt0, cnt1;
  logic [3:0] cnt2;
  logic [2:0][31:0] o_sum, o_cnt;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  bam_product_accumulator u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid[0]), .out_ready(out_ready), .out_sum(sum0), .out_count(cnt0), .out_sat(out_sat[0]));
  bam_product_accumulator #(.ACC_W(18)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid[1]), .out_ready(out_ready), .out_sum(sum1), .out_count(cnt1), .out_sat(out_sat[1]));
  bam_product_accumulator #(.CNT_W(4)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(out_valid[2]), .out_ready(out_ready), .out_sum(sum2), .out_count(cnt2), .out_sat(out_sat[2]));
  assign o_sum = {32'(sum2), 32'(sum1), 32'(sum0)};
  assign o_cnt = {32'(cnt2), 32'(cnt1), 32'(cnt0)};
  typedef struct packed {
    logic [2:0][31:0] sum;
    logic [2:0][31:0] cnt;
    logic [2:0]       sat;
  } exp_t;
  exp_t sb[$];
  int aw[3] = '{24, 18, 24};
  int cw[3] = '{8, 8, 4};
  longint m_acc[3], m_cnt[3];
  logic [2:0] m_sat;
  logic seen = 0;
  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0;
      m_cnt[i] = 0;
    end
    m_sat = 0;
  endtask
  task automatic send(input logic [15:0] p, input logic l);
    exp_t e;
    in_valid = 1; in_prod = p; in_last = l;
    total++;
    if (in_ready !== 3'b111) $display("FAIL send_ready: got %b want 111", in_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      m_acc[i] += longint'(p);
      if (m_acc[i] > (64'd1 << aw[i]) - 1) begin
        m_acc[i] = (64'd1 << aw[i]) - 1;
        m_sat[i] = 1;
      end
      if (m_cnt[i] < (64'd1 << cw[i]) - 1) m_cnt[i]++;
    end
    if (l) begin
      for (int i = 0; i < 3; i++) begin
        e.sum[i] = 32'(m_acc[i]);
        e.cnt[i] = 32'(m_cnt[i]);
      end
      e.sat = m_sat;
      sb.push_back(e);
      clear_model();
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; in_prod = 0;
  endtask
  always @(negedge clk) begin
    if (out_valid[0] && !seen) begin
      exp_t e;
      total++;
      if (sb.size() == 0) $display("FAIL sb_unexpected: got output sum %0d want no output", o_sum[0]);
      else begin
        passed++;
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
          total += 3;
          if (o_sum[i] !== e.sum[i]) $display("FAIL sb_sum[%0d]: got %0d want %0d", i, o_sum[i], e.sum[i]); else passed++;
          if (o_cnt[i] !== e.cnt[i]) $display("FAIL sb_count[%0d]: got %0d want %0d", i, o_cnt[i], e.cnt[i]); else passed++;
          if (out_sat[i] !== e.sat[i]) $display("FAIL sb_sat[%0d]: got %b want %b", i, out_sat[i], e.sat[i]); else passed++;
        end
      end
    end
    seen <= out_valid[0];
  end
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    clear_model();
    total += 5;
    if (out_valid !== 3'b000) $display("FAIL reset_valid: got %b want 000", out_valid); else passed++;
    if (in_ready !== 3'b111) $display("FAIL reset_ready: got %b want 111", in_ready); else passed++;
    if (sum0 !== 0) $display("FAIL reset_sum: got %0d want 0", sum0); else passed++;
    if (cnt0 !== 0) $display("FAIL reset_count: got %0d want 0", cnt0); else passed++;
    if (out_sat !== 3'b000) $display("FAIL reset_sat: got %b want 000", out_sat); else passed++;
  endtask
  task automatic test_basic();
    out_ready = 1;
    send(100, 0); send(200, 0); send(300, 1);
    total += 4;
    if (out_valid[0] !== 1) $display("FAIL basic_valid: got %b want 1", out_valid[0]); else passed++;
    if (sum0 !== 600) $display("FAIL basic_sum: got %0d want 600", sum0); else passed++;
    if (cnt0 !== 3) $display("FAIL basic_count: got %0d want 3", cnt0); else passed++;
    if (out_sat[0] !== 0) $display("FAIL basic_sat: got %b want 0", out_sat[0]); else passed++;
    @(posedge clk); #1;
  endtask
  task automatic test_saturate();
    out_ready = 1;
    for (int i = 0; i < 5; i++) send(16'hffff, i == 4);
    total += 4;
    if (sum1 !== 18'd262143) $display("FAIL sat18_sum: got %0d want 262143", sum1); else passed++;
    if (cnt1 !== 5) $display("FAIL sat18_count: got %0d want 5", cnt1); else passed++;
    if (out_sat[1] !== 1) $display("FAIL sat18_sat: got %b want 1", out_sat[1]); else passed++;
    if (sum0 !== 327675 || out_sat[0] !== 0) $display("FAIL sat24_sum: got %0d/%b want 327675/0", sum0, out_sat[0]); else passed++;
    @(posedge clk); #1;
  endtask
  task automatic test_hold();
    out_ready = 0;
    send(7, 0); send(8, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_last = 1; in_prod = 99;
      total += 3;
      if (in_ready[0] !== 0) $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready[0]); else passed++;
      if (out_valid[0] !== 1) $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid[0]); else passed++;
      if (sum0 !== 15) $display("FAIL hold_sum[%0d]: got %0d want 15", i, sum0); else passed++;
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0; in_prod = 0; out_ready = 1;
    @(posedge clk); #1;
    total += 2;
    if (out_valid[0] !== 0) $display("FAIL release_valid: got %b want 0", out_valid[0]); else passed++;
    if (in_ready[0] !== 1) $display("FAIL release_ready: got %b want 1", in_ready[0]); else passed++;
    send(5, 1);
    total += 2;
    if (sum0 !== 5) $display("FAIL carry_sum: got %0d want 5", sum0); else passed++;
    if (cnt0 !== 1) $display("FAIL carry_count: got %0d want 1", cnt0); else passed++;
    @(posedge clk); #1;
  endtask
  task automatic test_count_sat();
    out_ready = 1;
    for (int i = 0; i < 20; i++) send(1, i == 19);
    total += 3;
    if (cnt2 !== 4'd15) $display("FAIL cnt4_count: got %0d want 15", cnt2); else passed++;
    if (sum2 !== 20 || out_sat[2] !== 0) $display("FAIL cnt4_sum: got %0d/%b want 20/0", sum2, out_sat[2]); else passed++;
    if (cnt0 !== 20) $display("FAIL cnt8_count: got %0d want 20", cnt0); else passed++;
    @(posedge clk); #1;
  endtask
  task automatic test_back_to_back();
    out_ready = 1;
    send(10, 0); send(0, 1);
    total += 3;
    if (cnt0 !== 2 || sum0 !== 10) $display("FAIL zero_prod: got %0d/%0d want 10/2", sum0, cnt0); else passed++;
    if (in_ready[0] !== 0) $display("FAIL gap_ready: got %b want 0", in_ready[0]); else passed++;
    @(posedge clk); #1;
    if (in_ready[0] !== 1) $display("FAIL gap_reopen: got %b want 1", in_ready[0]); else passed++;
    send(0, 1);
    total++;
    if (cnt0 !== 1 || sum0 !== 0) $display("FAIL single_zero: got %0d/%0d want 0/1", sum0, cnt0); else passed++;
    @(posedge clk); #1;
  endtask
  task automatic test_reset_hold();
    out_ready = 0;
    send(100, 0); send(200, 0); send(300, 1);
    total++;
    if (sum0 !== 600) $display("FAIL rh_sum_before: got %0d want 600", sum0); else passed++;
    rst = 1; out_ready = 1;
    @(posedge clk); #1 rst = 0;
    clear_model();
    total += 3;
    if (out_valid[0] !== 0) $display("FAIL rh_valid: got %b want 0", out_valid[0]); else passed++;
    if (sum0 !== 0) $display("FAIL rh_sum: got %0d want 0", sum0); else passed++;
    if (in_ready[0] !== 1) $display("FAIL rh_ready: got %b want 1", in_ready[0]); else passed++;
    send(50, 0);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    clear_model();
    send(9, 1);
    total++;
    if (sum0 !== 9 || cnt0 !== 1) $display("FAIL rh_next: got %0d/%0d want 9/1", sum0, cnt0); else passed++;
    @(posedge clk); #1;
  endtask
  initial begin
    clear_model();
    test_reset();
    test_basic();
    test_saturate();
    test_hold();
    test_count_sat();
    test_back_to_back();
    test_reset_hold();
    repeat (2) @(posedge clk);
    #1 total++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
